// File: rtl/apb_agent_pkg.sv
// Shared APB agent types: protection/direction encodings and the arbiter FSM state.
package apb_agent_pkg;

  typedef struct packed {
    logic instr;
    logic nonsecure;
    logic privileged;
  } apb_pprot_t;

  typedef enum logic {
    APB_READ  = 1'b0,
    APB_WRITE = 1'b1
  } apb_write_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2
  } apb_arb_state_e;

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: searches from last_grant+1 upward, wrapping modulo N.
module apb_rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic          w_found;
  int            w_cand;
  logic [IW-1:0] w_cand_idx;

  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    w_found    = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand     = (int'(last_grant) + k) % N;
      w_cand_idx = IW'(w_cand);
      if (!w_found && req[w_cand_idx]) begin
        w_found           = 1'b1;
        grant[w_cand_idx] = 1'b1;
        grant_idx         = w_cand_idx;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that sequences granted requests onto a single APB requester bus
// and returns a registered, one-cycle response pulse to the granted requester.
module apb_req_arbiter
  import apb_agent_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic                              pclk,
  input  logic                              preset_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_strb,
  input  logic [NUM_REQ*3-1:0]              req_prot,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_slverr,
  output logic [ADDR_WIDTH-1:0]             paddr,
  output logic [2:0]                        pprot,
  output logic                              psel,
  output logic                              penable,
  output logic                              pwrite,
  output logic [DATA_WIDTH-1:0]             pwdata,
  output logic [DATA_WIDTH/8-1:0]           pstrb,
  input  logic                              pready,
  input  logic [DATA_WIDTH-1:0]             prdata,
  input  logic                              pslverr
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  apb_arb_state_e          r_state, w_state_next;
  logic [IW-1:0]           r_last_grant, r_gnt_idx;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  apb_pprot_t              r_pprot;
  apb_write_e              r_pwrite;
  logic [DATA_WIDTH-1:0]   r_pwdata, r_rsp_rdata;
  logic [SW-1:0]           r_pstrb;
  logic [NUM_REQ-1:0]      r_rsp_valid;
  logic                    r_rsp_slverr;

  logic [NUM_REQ-1:0]      w_pick, w_rsp_onehot;
  logic [IW-1:0]           w_pick_idx;
  logic                    w_done, w_take;
  logic [ADDR_WIDTH-1:0]   w_addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   w_wdata_arr [NUM_REQ];
  logic [SW-1:0]           w_strb_arr  [NUM_REQ];
  logic [2:0]              w_prot_arr  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi]   = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wdata_arr[gi]  = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_strb_arr[gi]   = req_strb[gi*SW +: SW];
      assign w_prot_arr[gi]   = req_prot[gi*3 +: 3];
      assign w_rsp_onehot[gi] = (r_gnt_idx == IW'(gi));
    end
  endgenerate

  apb_rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_pick),
    .grant_idx  (w_pick_idx)
  );

  // A grant is only possible when the bus is free now or frees up at this edge.
  assign w_done = (r_state == ARB_ACCESS) && pready;
  assign w_take = ((r_state == ARB_IDLE) || w_done) && (|req_valid);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) r_state <= ARB_IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_IDLE:   w_state_next = w_take ? ARB_SETUP : ARB_IDLE;
      ARB_SETUP:  w_state_next = ARB_ACCESS;
      ARB_ACCESS: if (pready) w_state_next = w_take ? ARB_SETUP : ARB_IDLE;
      default:    w_state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    psel      = (r_state != ARB_IDLE);
    penable   = (r_state == ARB_ACCESS);
    req_ready = w_take ? w_pick : '0;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_last_grant <= IW'(NUM_REQ - 1);
      r_gnt_idx    <= '0;
      r_paddr      <= '0;
      r_pprot      <= '0;
      r_pwrite     <= APB_READ;
      r_pwdata     <= '0;
      r_pstrb      <= '0;
    end else if (w_take) begin
      r_last_grant <= w_pick_idx;
      r_gnt_idx    <= w_pick_idx;
      r_paddr      <= w_addr_arr[w_pick_idx];
      r_pprot      <= apb_pprot_t'(w_prot_arr[w_pick_idx]);
      r_pwrite     <= apb_write_e'(req_write[w_pick_idx]);
      // Reads leave pwdata untouched to avoid needless bus toggling.
      if (req_write[w_pick_idx]) begin
        r_pwdata <= w_wdata_arr[w_pick_idx];
        r_pstrb  <= w_strb_arr[w_pick_idx];
      end else begin
        r_pstrb  <= '0;
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_slverr <= 1'b0;
    end else begin
      r_rsp_valid  <= w_done ? w_rsp_onehot : '0;
      r_rsp_rdata  <= (w_done && (r_pwrite == APB_READ)) ? prdata : '0;
      r_rsp_slverr <= w_done && pslverr;
    end
  end

  assign paddr      = r_paddr;
  assign pprot      = r_pprot;
  assign pwrite     = r_pwrite;
  assign pwdata     = r_pwdata;
  assign pstrb      = r_pstrb;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_slverr = r_rsp_slverr;

endmodule
